// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-transaction I2C master issuing indexed register writes/reads.
// Define I2C_MASTER_ACK_CHECK_EN to abort on NACK and report it on ACK_ERR.
module i2c_master_ctrl #(
    parameter int unsigned CLK_DIV  = 250,
    parameter logic [6:0]  DEV_ADDR = 7'h55
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       START,
    input  logic       RW,
    input  logic [7:0] INDEX,
    input  logic [7:0] WDATA,
    input  logic       SDA_IN,
    output logic       BUSY,
    output logic       DONE,
    output logic       ACK_ERR,
    output logic [7:0] RDATA,
    output logic       SCL,
    output logic       SDA_OUT
);

    localparam int unsigned    DW      = $clog2(CLK_DIV);
    localparam logic [DW-1:0]  DIV_MAX = DW'(CLK_DIV - 1);

    localparam logic [1:0] B_ADDR_W = 2'd0;
    localparam logic [1:0] B_INDEX  = 2'd1;
    localparam logic [1:0] B_WDATA  = 2'd2;
    localparam logic [1:0] B_ADDR_R = 2'd3;

    typedef enum logic [3:0] {
        IDLE, START_C, TX_BYTE, RX_ACK, RSTART,
        RX_BYTE, TX_NACK, STOP_C, FINISH
    } state_t;

    state_t        state;
    logic [1:0]    q;
    logic [DW-1:0] div;
    logic [2:0]    bit_cnt;
    logic [1:0]    byte_sel;
    logic [7:0]    tx_sh;
    logic [7:0]    rx_sh;
    logic [7:0]    idx_l;
    logic [7:0]    wd_l;
    logic          rw_l;
    logic          tick;

    assign tick = BUSY && (div == DIV_MAX);

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state    <= IDLE;
            q        <= 2'd0;
            div      <= '0;
            bit_cnt  <= 3'd0;
            byte_sel <= B_ADDR_W;
            tx_sh    <= 8'h00;
            rx_sh    <= 8'h00;
            idx_l    <= 8'h00;
            wd_l     <= 8'h00;
            rw_l     <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ACK_ERR  <= 1'b0;
            RDATA    <= 8'h00;
            SCL      <= 1'b1;
            SDA_OUT  <= 1'b1;
        end else begin
            DONE <= 1'b0;
            if (BUSY)
                div <= tick ? '0 : div + DW'(1);
            if (tick)
                q <= q + 2'd1;
            unique case (state)
                IDLE: if (START) begin
                    state    <= START_C;
                    q        <= 2'd0;
                    div      <= '0;
                    bit_cnt  <= 3'd0;
                    byte_sel <= B_ADDR_W;
                    tx_sh    <= {DEV_ADDR, 1'b0};
                    idx_l    <= INDEX;
                    wd_l     <= WDATA;
                    rw_l     <= RW;
                    BUSY     <= 1'b1;
                    ACK_ERR  <= 1'b0;
                end
                START_C: if (tick) unique case (q)
                    2'd0: SDA_OUT <= 1'b0;
                    2'd1: SCL <= 1'b0;
                    2'd2: ;
                    2'd3: begin
                        state   <= TX_BYTE;
                        SDA_OUT <= tx_sh[7];
                    end
                endcase
                TX_BYTE: if (tick) unique case (q)
                    2'd0: ;
                    2'd1: SCL <= 1'b1;
                    2'd2: ;
                    2'd3: begin
                        SCL     <= 1'b0;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state   <= RX_ACK;
                            SDA_OUT <= 1'b1;
                        end else begin
                            tx_sh   <= {tx_sh[6:0], 1'b0};
                            SDA_OUT <= tx_sh[6];
                        end
                    end
                endcase
                RX_ACK: if (tick) unique case (q)
                    2'd0: ;
                    2'd1: SCL <= 1'b1;
                    2'd2: begin
`ifdef I2C_MASTER_ACK_CHECK_EN
                        ACK_ERR <= SDA_IN;
`endif
                    end
                    2'd3: begin
                        SCL <= 1'b0;
`ifdef I2C_MASTER_ACK_CHECK_EN
                        if (ACK_ERR) begin
                            state   <= STOP_C;
                            SDA_OUT <= 1'b0;
                        end else
`endif
                        unique case (byte_sel)
                            B_ADDR_W: begin
                                state    <= TX_BYTE;
                                tx_sh    <= idx_l;
                                SDA_OUT  <= idx_l[7];
                                byte_sel <= B_INDEX;
                            end
                            // Reads turn the bus around with a repeated START
                            B_INDEX: if (rw_l) begin
                                state    <= RSTART;
                                tx_sh    <= {DEV_ADDR, 1'b1};
                                byte_sel <= B_ADDR_R;
                            end else begin
                                state    <= TX_BYTE;
                                tx_sh    <= wd_l;
                                SDA_OUT  <= wd_l[7];
                                byte_sel <= B_WDATA;
                            end
                            B_WDATA: begin
                                state   <= STOP_C;
                                SDA_OUT <= 1'b0;
                            end
                            B_ADDR_R: state <= RX_BYTE;
                        endcase
                    end
                endcase
                RSTART: if (tick) unique case (q)
                    2'd0: SCL <= 1'b1;
                    2'd1: SDA_OUT <= 1'b0;
                    2'd2: SCL <= 1'b0;
                    2'd3: begin
                        state   <= TX_BYTE;
                        SDA_OUT <= tx_sh[7];
                    end
                endcase
                RX_BYTE: if (tick) unique case (q)
                    2'd0: ;
                    2'd1: SCL <= 1'b1;
                    2'd2: rx_sh <= {rx_sh[6:0], SDA_IN};
                    2'd3: begin
                        SCL     <= 1'b0;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= TX_NACK;
                    end
                endcase
                TX_NACK: if (tick) unique case (q)
                    2'd0: ;
                    2'd1: SCL <= 1'b1;
                    2'd2: ;
                    2'd3: begin
                        SCL     <= 1'b0;
                        SDA_OUT <= 1'b0;
                        state   <= STOP_C;
                    end
                endcase
                STOP_C: if (tick) unique case (q)
                    2'd0: SCL <= 1'b1;
                    2'd1: SDA_OUT <= 1'b1;
                    2'd2: ;
                    2'd3: begin
                        state <= FINISH;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        if (rw_l && !ACK_ERR)
                            RDATA <= rx_sh;
                    end
                endcase
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: randomized bench for i2c_master_ctrl with a behavioural register slave.
// Expected outcomes come from a command-level register model.
module tb_i2c_master_ctrl;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned BIT_CYC = 4 * CLK_DIV;

    logic       CLK;
    logic       RSTN;
    logic       START;
    logic       RW;
    logic [7:0] INDEX;
    logic [7:0] WDATA;
    logic       BUSY;
    logic       DONE;
    logic       ACK_ERR;
    logic [7:0] RDATA;
    logic       SCL;
    logic       SDA_OUT;

    bit         s_drv = 1'b1;
    wire        sda_bus = SDA_OUT & s_drv;

    i2c_master_ctrl #(
        .CLK_DIV  (CLK_DIV),
        .DEV_ADDR (7'h55)
    ) dut (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .START   (START),
        .RW      (RW),
        .INDEX   (INDEX),
        .WDATA   (WDATA),
        .SDA_IN  (sda_bus),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ACK_ERR (ACK_ERR),
        .RDATA   (RDATA),
        .SCL     (SCL),
        .SDA_OUT (SDA_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Behavioural I2C register slave, evaluated on bus levels at negedge
    bit [7:0] s_regs [256];
    bit [6:0] slv_addr = 7'h55;
    bit [7:0] s_sh, s_idx;
    bit       s_act, s_armed, s_rd, s_rdp, s_mnack;
    bit       p_scl = 1'b1, p_sda = 1'b1;
    int       s_bit, s_byte;

    always @(negedge CLK) begin
        if (p_scl && SCL && p_sda && !sda_bus) begin
            s_act = 1; s_armed = 0; s_bit = 0; s_byte = 0;
            s_rd = 0; s_rdp = 0; s_drv = 1;
        end else if (p_scl && SCL && !p_sda && sda_bus) begin
            s_act = 0; s_idx = 0; s_drv = 1;
        end else if (s_act && !p_scl && SCL) begin
            if (s_bit < 8 && !s_rd) s_sh = {s_sh[6:0], sda_bus};
            if (s_bit == 8) s_mnack = sda_bus;
        end else if (s_act && p_scl && !SCL) begin
            if (!s_armed) begin
                s_armed = 1;
            end else if (s_bit == 8) begin
                s_bit = 0; s_drv = 1; s_byte++;
                if (s_rd && s_mnack) begin
                    s_act = 0;
                end else if (s_rd || s_rdp) begin
                    s_rd = 1; s_sh = s_regs[s_idx]; s_idx++;
                    s_drv = s_sh[7];
                end
            end else if (s_bit == 7) begin
                s_bit = 8;
                if (s_rd) begin
                    s_drv = 1;
                end else if (s_byte == 0) begin
                    if (s_sh[7:1] == slv_addr) begin
                        s_drv = 0; s_rdp = s_sh[0];
                    end else begin
                        s_act = 0; s_drv = 1;
                    end
                end else begin
                    if (s_byte == 1) s_idx = s_sh;
                    else begin s_regs[s_idx] = s_sh; s_idx++; end
                    s_drv = 0;
                end
            end else begin
                s_bit++;
                if (s_rd) begin s_sh = s_sh << 1; s_drv = s_sh[7]; end
            end
        end
        p_scl = SCL;
        p_sda = SDA_OUT & s_drv;
    end

    // Command-level reference model
    bit [7:0] exp_regs [256];
    bit [7:0] exp_rdata = 8'h00;

    task automatic do_txn(input bit rw, input bit [7:0] idx, input bit [7:0] wd,
                          input int poke, output int busy_n, output int done_n,
                          output int to_done);
        int n;
        busy_n = 0; done_n = 0; to_done = -1;
        @(negedge CLK);
        RW = rw; INDEX = idx; WDATA = wd; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        INDEX = 8'($urandom); WDATA = 8'($urandom); RW = 1'($urandom);
        if (BUSY) busy_n++;
        n = 1;
        while (to_done < 0 && n < 3000) begin
            @(posedge CLK);
            #1;
            n++;
            if (BUSY) busy_n++;
            if (DONE) begin done_n++; to_done = n; end
            if (poke != 0 && n == poke) begin
                START = 1'b1; RW = rw; INDEX = idx ^ 8'h01; WDATA = ~wd;
            end else begin
                START = 1'b0;
            end
        end
        START = 1'b0;
        check("done_seen", 32'(to_done > 0), 1);
        repeat (8) begin
            @(posedge CLK);
            #1;
            if (DONE) done_n++;
            if (BUSY) busy_n++;
        end
    endtask

    int b, d, t;

    initial begin
        bit       rw;
        bit [7:0] idx, wd;

        RSTN = 1'b0; START = 1'b0; RW = 1'b0; INDEX = 8'h00; WDATA = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_scl", SCL, 1);
        check("rst_sda", SDA_OUT, 1);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_ackerr", ACK_ERR, 0);
        check("rst_rdata", RDATA, 8'h00);
        @(negedge CLK);
        RSTN = 1'b1;
        repeat (3) @(negedge CLK);

        // Directed write then read-back
        do_txn(0, 8'h02, 8'hA5, 0, b, d, t);
        exp_regs[8'h02] = 8'hA5;
        check("wr_busy_cyc", b, 29 * BIT_CYC);
        check("wr_to_done", t, 29 * BIT_CYC + 1);
        check("wr_done_n", d, 1);
        check("wr_ackerr", ACK_ERR, 0);
        check("wr_rdata_kept", RDATA, exp_rdata);

        do_txn(1, 8'h02, 8'h00, 0, b, d, t);
        exp_rdata = exp_regs[8'h02];
        check("rd_rdata", RDATA, 8'hA5);
        check("rd_done_n", d, 1);
        check("rd_ackerr", ACK_ERR, 0);

        // Random traffic against the register model
        for (int i = 0; i < 16; i++) begin
            rw  = 1'($urandom);
            idx = 8'($urandom_range(0, 7));
            wd  = 8'($urandom);
            do_txn(rw, idx, wd, 0, b, d, t);
            if (rw) exp_rdata = exp_regs[idx];
            else exp_regs[idx] = wd;
            check("rnd_rdata", RDATA, exp_rdata);
            check("rnd_done_n", d, 1);
            check("rnd_ackerr", ACK_ERR, 0);
            if (!rw) check("rnd_wr_busy", b, 29 * BIT_CYC);
        end

        // START pulsed mid-write is ignored
        do_txn(0, 8'h03, 8'h3C, 100, b, d, t);
        exp_regs[8'h03] = 8'h3C;
        check("poke_done_n", d, 1);
        check("poke_busy", b, 29 * BIT_CYC);
        do_txn(1, 8'h02, 8'h00, 0, b, d, t);
        exp_rdata = exp_regs[8'h02];
        check("poke_rd_other", RDATA, exp_rdata);
        do_txn(1, 8'h03, 8'h00, 0, b, d, t);
        exp_rdata = exp_regs[8'h03];
        check("poke_rd", RDATA, exp_rdata);

        // Reset during bit 5 of INDEX (quarter 0, SCL low)
        @(negedge CLK);
        RW = 1'b0; INDEX = 8'h09; WDATA = 8'hE7; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (10 * BIT_CYC + 5 * BIT_CYC + 1) @(posedge CLK);
        #1;
        check("mid_busy", BUSY, 1);
        check("mid_scl", SCL, 0);
        check("mid_sda", SDA_OUT, 0);
        @(negedge CLK);
        RSTN = 1'b0;
        @(posedge CLK);
        #1;
        check("mrst_scl", SCL, 1);
        check("mrst_sda", SDA_OUT, 1);
        check("mrst_busy", BUSY, 0);
        check("mrst_done", DONE, 0);
        @(negedge CLK);
        RSTN = 1'b1;
        exp_rdata = 8'h00;
        repeat (4) @(negedge CLK);
        do_txn(1, 8'h09, 8'h00, 0, b, d, t);
        exp_rdata = exp_regs[8'h09];
        check("mrst_rd", RDATA, exp_rdata);

        // Target does not answer its address
        slv_addr = 7'h11;
        do_txn(0, 8'h05, 8'h5A, 0, b, d, t);
        check("nack_wr_done_n", d, 1);
`ifdef I2C_MASTER_ACK_CHECK_EN
        check("nack_wr_ackerr", ACK_ERR, 1);
        check("nack_wr_busy", b, 11 * BIT_CYC);
`else
        check("nack_wr_ackerr", ACK_ERR, 0);
        check("nack_wr_busy", b, 29 * BIT_CYC);
`endif
        do_txn(1, 8'h05, 8'h00, 0, b, d, t);
`ifdef I2C_MASTER_ACK_CHECK_EN
        check("nack_rd_ackerr", ACK_ERR, 1);
        check("nack_rd_busy", b, 11 * BIT_CYC);
`else
        exp_rdata = 8'hFF;
        check("nack_rd_ackerr", ACK_ERR, 0);
`endif
        check("nack_rd_rdata", RDATA, exp_rdata);
        slv_addr = 7'h55;
        do_txn(1, 8'h05, 8'h00, 0, b, d, t);
        exp_rdata = exp_regs[8'h05];
        check("post_nack_rd", RDATA, exp_rdata);
        check("post_nack_ackerr", ACK_ERR, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
